// File: rtl/exec_divider_if.sv
// exec_divider_if: request/response bundle between the execute stage and the iterative divider.
interface exec_divider_if #(parameter int DATA_WIDTH = 64);
  logic                  i_start;
  logic                  i_flush;
  logic [2:0]            i_func3;
  logic                  i_word;
  logic [DATA_WIDTH-1:0] i_rs1_data;
  logic [DATA_WIDTH-1:0] i_rs2_data;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_result;
  modport master (output i_start, i_flush, i_func3, i_word, i_rs1_data, i_rs2_data,
                  input  o_busy, o_done, o_result);
  modport slave  (input  i_start, i_flush, i_func3, i_word, i_rs1_data, i_rs2_data,
                  output o_busy, o_done, o_result);
endinterface

// File: rtl/exec_divider.sv
// exec_divider: iterative restoring radix-2 RV64M divide unit (DIV/DIVU/REM/REMU and W forms).
module exec_divider #(parameter int DATA_WIDTH = 64) (
  input logic          i_clk,
  input logic          i_arstn,
  exec_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MIN_W = {{(DATA_WIDTH-31){1'b1}}, 31'b0};
  function automatic logic [DATA_WIDTH-1:0] fmt(input logic w, input logic [DATA_WIDTH-1:0] x);
    return w ? {{(DATA_WIDTH-32){x[31]}}, x[31:0]} : x;
  endfunction
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rem_q, quot_q, div_q, result_q;
  logic                  busy_q, done_q, word_q, rem_op_q, neg_q_q, neg_r_q;
  logic                  op_signed, op_rem, a_neg, b_neg, div_zero, ovf, ge;
  logic [DATA_WIDTH-1:0] a_ext, b_ext, a_abs, b_abs, spec_res, rem_nx, quot_nx, fin;
  logic [DATA_WIDTH:0]   trial, diff;
  // func3[2]==0 is not a divide encoding; it decodes as DIVU
  assign op_signed = bus.i_func3[2] & ~bus.i_func3[0];
  assign op_rem    = bus.i_func3[2] & bus.i_func3[1];
  assign a_ext = bus.i_word ? {{(DATA_WIDTH-32){op_signed & bus.i_rs1_data[31]}}, bus.i_rs1_data[31:0]} : bus.i_rs1_data;
  assign b_ext = bus.i_word ? {{(DATA_WIDTH-32){op_signed & bus.i_rs2_data[31]}}, bus.i_rs2_data[31:0]} : bus.i_rs2_data;
  assign a_neg = op_signed & a_ext[DATA_WIDTH-1];
  assign b_neg = op_signed & b_ext[DATA_WIDTH-1];
  assign a_abs = a_neg ? -a_ext : a_ext;
  assign b_abs = b_neg ? -b_ext : b_ext;
  assign div_zero = b_ext == '0;
  assign ovf = op_signed && a_ext == (bus.i_word ? MIN_W : MIN) && b_ext == ONES;
  assign spec_res = fmt(bus.i_word, div_zero ? (op_rem ? a_ext : ONES) : (op_rem ? '0 : a_ext));
  // one extra bit: the shifted partial remainder can reach twice the divisor
  assign trial   = {rem_q, quot_q[DATA_WIDTH-1]};
  assign diff    = trial - {1'b0, div_q};
  assign ge      = trial >= {1'b0, div_q};
  assign rem_nx  = ge ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  assign quot_nx = {quot_q[DATA_WIDTH-2:0], ge};
  assign fin = fmt(word_q, rem_op_q ? (neg_r_q ? -rem_nx : rem_nx) : (neg_q_q ? -quot_nx : quot_nx));
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_result = result_q;
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      div_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      word_q   <= 1'b0;
      rem_op_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (bus.i_flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.i_start) begin
            word_q   <= bus.i_word;
            rem_op_q <= op_rem;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            if (div_zero || ovf) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= spec_res;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
              cnt    <= bus.i_word ? CW'(32) : CW'(DATA_WIDTH);
              rem_q  <= '0;
              // word dividends are pre-aligned so their MSB shifts out first
              quot_q <= bus.i_word ? {a_abs[31:0], {(DATA_WIDTH-32){1'b0}}} : a_abs;
              div_q  <= b_abs;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin;
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/exec_divider.md
# exec_divider

Iterative RV64M divide unit in the execute stage. It consumes the operands, func3 and control that the decode/execute pipeline register delivers. It computes DIV/DIVU/REM/REMU and their 32-bit W forms with a restoring radix-2 algorithm, one quotient bit per cycle. While it works it holds the pipeline through `o_busy`, and it returns the result to the execute result mux with a one-cycle `o_done` pulse.

## Interface
- `DATA_WIDTH`, 64: operand and result width (XLEN).
- `i_clk`  in  1  clock, rising edge.
- `i_arstn`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  request a divide; sampled only in IDLE.
- `i_flush`  in  1  abort any operation in progress (execute flush).
- `i_func3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes treated as DIVU.
- `i_word`  in  1  W variant (DIVW/DIVUW/REMW/REMUW).
- `i_rs1_data`  in  DATA_WIDTH  dividend.
- `i_rs2_data`  in  DATA_WIDTH  divisor.
- `o_busy`  out  1  high while iterating (state CALC); the hazard unit stalls fetch/decode on it.
- `o_done`  out  1  one-cycle pulse; `o_result` valid in this cycle.
- `o_result`  out  DATA_WIDTH  quotient or remainder. Registered; holds until the next completion.

## Operation
- FSM states: IDLE, CALC, DONE. Reset (`i_arstn`=0, async) sets:
  - state = IDLE
  - `o_busy` = 0, `o_done` = 0, `o_result` = 0
  - iteration counter and internal remainder/quotient = 0
- IDLE, `i_start`=1, `i_flush`=0: latch the operation (signed = !func3[0], rem = func3[1], word = `i_word`).
- Operand preparation:
  - Word ops use bits [31:0].
  - Signed ops take absolute values, sign-extended from bit 31 (word) or bit 63.
  - Record sign of quotient = sign(dividend) XOR sign(divisor); sign of remainder = sign(dividend).
- Special cases resolve at the start edge and go IDLE->DONE directly:
  - Divisor zero (in the active width): quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1 in the active width): quotient = dividend; remainder = 0.
- Normal path: IDLE->CALC, counter = N (64, or 32 for word).
  - Each CALC edge: shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient LSB on non-negative, decrement the counter.
  - The edge performing the last iteration moves to DONE and registers the sign-corrected result.
- Result formatting: negate the quotient/remainder according to the recorded sign. Word ops sign-extend bit 31 to DATA_WIDTH for all four W variants, including unsigned.
- DONE: `o_done`=1 for exactly one cycle, then IDLE.
- `i_start` while in CALC or DONE is ignored. There is no queueing.
- `i_flush`=1 in any state: next edge goes to IDLE.
  - No `o_done` is generated for the aborted operation.
  - `o_result` is unchanged.
  - Flush takes priority over a simultaneous `i_start`.
- Flush in DONE: the `o_done` pulse already visible in that cycle stands. The result register has already been written.

## Timing
- Normal latency: `i_start` sampled at edge 0, `o_busy` high after edges 0..N-1, `o_done` high in the cycle after edge N.
  - 64-bit: 65 cycles from start to the done cycle.
  - Word: 33 cycles.
- Special-case latency: `o_done` in the cycle after the start edge (1 cycle); `o_busy` never asserts.
- `o_busy`, `o_done` and `o_result` are registered outputs. There are no combinational paths from the inputs to the outputs.
- Back-to-back: a new `i_start` is accepted in the cycle after DONE (IDLE). There is a minimum of one idle cycle between operations.
- Operand inputs are sampled only at the start edge and may change afterwards.

## Test plan
- DIVU 100/7 -> `o_done` at cycle 65, `o_result`=14. Repeat as REMU -> 2. `o_busy` is high for exactly 64 cycles.
- DIV -100/7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14). REM -> 0xFFFF_FFFF_FFFF_FFFE (-2). DIV 100/-7 -> -14. REM 100/-7 -> 2.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5/0 -> 5.
  - Each completes with `o_done` one cycle after start, and `o_busy` never high.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, and REM -> 0. DIVW with rs1[31:0]=0x8000_0000, rs2=-1 -> 0xFFFF_FFFF_8000_0000.
- Word ops:
  - DIVW rs1=0x1234_5678_FFFF_FFF9 (-7), rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3), with `o_done` at cycle 33.
  - DIVUW 0x8000_0000/1 -> 0xFFFF_FFFF_8000_0000.
- Abort and reset:
  - `i_flush` in the 10th CALC cycle: `o_busy` low next cycle, no `o_done`, `o_result` keeps its prior value. A following DIVU 9/3 returns 3.
  - `i_arstn` pulsed mid-CALC: all outputs are 0 immediately, and the next start completes normally.
  - `i_start` asserted during CALC is ignored.
